// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART state encoding, default rates and rate helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int unsigned DEFAULT_CLK_FREQ = 50_000_000;
    localparam int unsigned DEFAULT_BAUD     = 115_200;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_e;

    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                      input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/synchronizer.sv
// ============================================================================
// Module      : synchronizer
// Description : Two-flop synchronizer per bit with configurable reset value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module synchronizer #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with mid-bit sampling and frame-error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int unsigned BAUD     = DEFAULT_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       UART_RXD,
    output logic [7:0] receive_data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] C_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_HALF_END = CNT_W'(HALF_BIT - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_rate
            $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
        end
    endgenerate

    logic              rx_s;
    uart_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic [7:0]        data_q;
    logic              valid_q;
    logic              ferr_q;
    logic              w_bit_end;
    logic              w_half_end;

    synchronizer #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (UART_RXD),
        .q_o (rx_s)
    );

    assign w_bit_end  = (cnt_q == C_BIT_END);
    assign w_half_end = (cnt_q == C_HALF_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                    end
                end
                ST_START: begin
                    // A start bit must still be low at its midpoint, else it was a glitch
                    if (w_half_end) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            state_q   <= ST_DATA;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        shift_q <= {rx_s, shift_q[7:1]};
                        cnt_q   <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    // A break holds the line low; only a return to idle re-arms the receiver
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign receive_data = data_q;
    assign valid        = valid_q;
    assign frame_err    = ferr_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

`default_nettype wire
